// File: rtl/cache_dm_ctrl.sv
// Direct-mapped write-through, no-write-allocate read cache with a fixed-latency memory port.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_dm_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int MEM_LAT  = 4
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              hit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    localparam int LINES      = 1 << INDEX_W;
    localparam int LINE_WORDS = 1 << OFFSET_W;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int C_W        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                replay_q, replay_d;
    logic [OFFSET_W-1:0] w_q, w_d;
    logic [C_W-1:0]      c_q, c_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                hit_q, hit_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0]   data_mem [0:LINES*LINE_WORDS-1];
    logic [TAG_W-1:0]    tag_mem  [0:LINES-1];

    logic [TAG_W-1:0]            tag_s;
    logic [INDEX_W-1:0]          index_s;
    logic [OFFSET_W-1:0]         offset_s;
    logic [OFFSET_W-1:0]         w_inc_s;
    logic                        match_s;
    logic                        c_last_s;
    logic                        arr_we_s;
    logic [INDEX_W+OFFSET_W-1:0] arr_addr_s;
    logic [DATA_W-1:0]           arr_wdata_s;
    logic                        tag_we_s;
    logic                        hit_inc_s;
    logic                        miss_inc_s;

    assign tag_s    = addr_q[ADDR_W-1 -: TAG_W];
    assign index_s  = addr_q[OFFSET_W +: INDEX_W];
    assign offset_s = addr_q[OFFSET_W-1:0];
    assign w_inc_s  = w_q + OFFSET_W'(1);
    assign match_s  = valid_q[index_s] && (tag_mem[index_s] == tag_s);
    assign c_last_s = (c_q == C_W'(MEM_LAT - 1));

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        replay_d    = replay_q;
        w_d         = w_q;
        c_d         = c_q;
        valid_d     = valid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        hit_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we_s    = 1'b0;
        arr_addr_s  = {index_s, offset_s};
        arr_wdata_s = wdata_q;
        tag_we_s    = 1'b0;
        hit_inc_s   = 1'b0;
        miss_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    replay_d = 1'b0;
                    state_d  = ST_LOOKUP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (we_q) begin
                    // Write-through: refresh the cached copy only when the line is present.
                    arr_we_s    = match_s;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    c_d         = '0;
                    state_d     = ST_WRITE;
                end else if (match_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = data_mem[{index_s, offset_s}];
                    hit_d       = ~replay_q;
                    hit_inc_s   = ~replay_q;
                    state_d     = ST_IDLE;
                end else begin
                    miss_inc_s = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {tag_s, index_s, {OFFSET_W{1'b0}}};
                    w_d        = '0;
                    c_d        = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (c_last_s) begin
                    arr_we_s    = 1'b1;
                    arr_addr_s  = {index_s, w_q};
                    arr_wdata_s = mem_rdata;
                    c_d         = '0;
                    w_d         = w_inc_s;
                    if (w_q == OFFSET_W'(LINE_WORDS - 1)) begin
                        tag_we_s         = 1'b1;
                        valid_d[index_s] = 1'b1;
                        mem_rd_d         = 1'b0;
                        replay_d         = 1'b1;
                        state_d          = ST_LOOKUP;
                    end else begin
                        mem_addr_d = {tag_s, index_s, w_inc_s};
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end
            ST_WRITE: begin
                if (c_last_s) begin
                    mem_wr_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    c_d         = '0;
                    state_d     = ST_IDLE;
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // Control state, valid bits and registered outputs.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            replay_q    <= 1'b0;
            w_q         <= '0;
            c_q         <= '0;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            hit_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            replay_q    <= replay_d;
            w_q         <= w_d;
            c_q         <= c_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            hit_q       <= hit_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Data and tag storage; contents are meaningful only where the valid bit is set.
    always_ff @(posedge clk_100) begin
        if (arr_we_s) begin
            data_mem[arr_addr_s] <= arr_wdata_s;
        end
        if (tag_we_s) begin
            tag_mem[index_s] <= tag_s;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_misses_q, stat_misses_d;

    // Saturating statistics increments.
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (hit_inc_s && (stat_hits_q != 16'hFFFF)) begin
            stat_hits_d = stat_hits_q + 16'd1;
        end else begin
            stat_hits_d = stat_hits_q;
        end
        if (miss_inc_s && (stat_misses_q != 16'hFFFF)) begin
            stat_misses_d = stat_misses_q + 16'd1;
        end else begin
            stat_misses_d = stat_misses_q;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_q   <= 16'd0;
            stat_misses_q <= 16'd0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = hit_inc_s ^ miss_inc_s;
`endif

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign hit       = hit_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
